tick_session_ctrl: RTL
======================

TICK_SESSION_CTRL -- requirements
Module: tick_session_ctrl

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset. Clock port: clk. Reset port: rst_n.
REQ-002 Parameter CLK_F SHALL default to 25000000 and gives the clock frequency in Hz.
REQ-003 Parameter MAX_TICKS SHALL default to 96000 and is the tick generator saturation count.
REQ-004 Parameter DEB_CYCLES SHALL default to 250000 (10 ms) and sets the debounce stable-time in clocks.
REQ-005 Port clk  in  1  system clock.
REQ-006 Port rst_n  in  1  synchronous reset, active low.
REQ-007 Port btn  in  1  raw, asynchronous push-button level.
REQ-008 Port target  in  17  stop-at tick count; 0 means run until button release.
REQ-009 Port gen_ticks  in  17  tick count returned by the tick generator, one clock of lag.
REQ-010 Port gen_start  out  1  run enable to the tick generator; low clears the generator.
REQ-011 Port res_ticks  out  17  latched session result.
REQ-012 Port res_valid  out  1  result available.
REQ-013 Port res_ready  in  1  consumer accepts the result.
REQ-014 Port busy  out  1  high in every state except IDLE.
REQ-015 Port overflow  out  1  the session ended at MAX_TICKS; qualified by res_valid.

Function
REQ-016 btn SHALL pass through a 2-flop synchronizer, then the debouncer, giving btn_clean.
REQ-017 The FSM SHALL have the states IDLE, RUN, STOP and REPORT.
REQ-018 In IDLE, a btn_clean rising edge SHALL latch target into tgt_q and move to RUN, with gen_start high from the next cycle.
REQ-019 In RUN, gen_start SHALL stay high.
REQ-020 A session SHALL end on the first of three conditions:
- (a) tgt_q!=0 and gen_ticks>=tgt_q;
- (b) gen_ticks==MAX_TICKS;
- (c) btn_clean falls.
REQ-021 When two or more end conditions occur in the same cycle, the priority SHALL be a > b > c.
REQ-022 On the ending cycle, the block SHALL:
- latch res_ticks = min(gen_ticks, tgt_q) when tgt_q!=0, else gen_ticks;
- set overflow = (gen_ticks==MAX_TICKS) when b applies, else 0.
REQ-023 From RUN the FSM SHALL enter STOP for exactly one cycle with gen_start low, then enter REPORT.
REQ-024 In REPORT, res_valid SHALL be high, and res_ticks and overflow SHALL be held stable.
REQ-025 In REPORT, res_valid&&res_ready SHALL return the FSM to IDLE on the next cycle, with res_valid low.
REQ-026 In IDLE, a rising edge while res_valid is high SHALL be ignored; a new session needs a fresh edge after the handshake.
REQ-027 A button held through REPORT SHALL NOT start a new session.
REQ-028 target changes during RUN SHALL have no effect; only tgt_q is used.
REQ-029 Comparisons SHALL be unsigned 17-bit, and target > MAX_TICKS SHALL behave as overflow-terminated.

Reset
REQ-030 While rst_n=0 at a clk edge, the block SHALL set:
- FSM to IDLE;
- gen_start=0, res_valid=0, res_ticks=0, overflow=0, busy=0;
- tgt_q=0, synchronizer and debounce state = 0.
REQ-031 Reset mid-RUN SHALL drop gen_start the same edge, and the in-progress count SHALL be discarded.

Configuration
REQ-032 With TICK_SESSION_DEBOUNCE_EN defined, btn_clean SHALL change only after the synchronized btn is stable for DEB_CYCLES clocks.
REQ-033 Without TICK_SESSION_DEBOUNCE_EN, btn_clean SHALL equal the synchronized btn (2-cycle latency), and the debounce counter SHALL be absent.

Structure
REQ-034 Shared package tick_pkg SHALL hold CLK_F, MAX_TICKS, TICK_W=17 and the FSM state typedef.
REQ-035 The debouncer SHALL be a separate sub-module, btn_debouncer, parameterised by DEB_CYCLES.

Verification (sim params MAX_TICKS=20, DEB_CYCLES=4, generator model counts +1/clk)
REQ-036 The bench SHALL drive target=8 and hold btn; required response: res_ticks=8, overflow=0, gen_start low 1 cycle before res_valid.
REQ-037 The bench SHALL drive target=0, hold btn, and release when gen_ticks=5; required response: res_ticks=5 (±debounce lag, checked exactly), overflow=0.
REQ-038 The bench SHALL drive target=0 and hold btn past 20; required response: res_ticks=20, overflow=1.
REQ-039 The bench SHALL hold res_ready=0 for 10 cycles in REPORT while btn toggles; required response: res_valid stays 1, result stable, no new session, and IDLE reached one cycle after res_ready=1.
REQ-040 The bench SHALL assert rst_n=0 during RUN at gen_ticks=3; required response: next edge shows gen_start=0, busy=0, res_valid=0, res_ticks=0.
REQ-041 The bench SHALL apply a 2-cycle btn glitch; required response: no session with TICK_SESSION_DEBOUNCE_EN defined, and a session started without it.

Source files
------------

// File: rtl/tick_pkg.sv
// Purpose: shared constants, session FSM encoding and result clamp for tick_session_ctrl.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tick_pkg;

  localparam int unsigned CLK_F     = 25000000;
  localparam int unsigned MAX_TICKS = 96000;
  localparam int unsigned TICK_W    = 17;

  // Session FSM encoding, kept as plain vector constants for legacy tools
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_RUN    = 2'd1;
  localparam state_t ST_STOP   = 2'd2;
  localparam state_t ST_REPORT = 2'd3;

  // Session result: capped at the stop-at target, a zero target means no cap
  function automatic logic [TICK_W-1:0] clamp_ticks(input logic [TICK_W-1:0] ticks,
                                                    input logic [TICK_W-1:0] tgt);
    logic [TICK_W-1:0] result;
    result = ticks;
    if ((tgt != '0) && (ticks > tgt)) begin
      result = tgt;
    end
    return result;
  endfunction

endpackage

// File: rtl/btn_debouncer.sv
// Purpose: 2-flop synchronizer plus optional stable-time filter for the push-button (TICK_SESSION_DEBOUNCE_EN).
// Latency: 2 clocks without the filter, 2 + DEB_CYCLES clocks with it.
// Backpressure: none; free-running level path.
module btn_debouncer #(
  parameter int unsigned DEB_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic btn_clean_o
);

  logic sync1_q;
  logic sync2_q;

  // Two-flop synchronizer for the asynchronous button level
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
    end
  end

`ifdef TICK_SESSION_DEBOUNCE_EN
  localparam int unsigned CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             clean_q;
  logic             clean_d;

  // Count consecutive clocks the synchronized level disagrees with the clean level;
  // any agreement restarts the count, so only a level held DEB_CYCLES clocks gets through
  always_comb begin
    cnt_d   = '0;
    clean_d = clean_q;
    if (sync2_q != clean_q) begin
      if (cnt_q == CNT_LAST) begin
        clean_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Filter state registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      clean_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
    end
  end

  assign btn_clean_o = clean_q;
`else
  assign btn_clean_o = sync2_q;
`endif

endmodule

// File: rtl/tick_session_ctrl.sv
// Purpose: button-driven tick session controller (start, stop on target/saturation/release, report); TICK_SESSION_DEBOUNCE_EN enables the button filter.
// Latency: gen_start rises 1 clock after a clean press edge; res_valid rises 2 clocks after the ending condition.
// Backpressure: result is held in REPORT until res_valid && res_ready; the button is ignored meanwhile.
module tick_session_ctrl #(
  parameter int unsigned CLK_F      = tick_pkg::CLK_F,
  parameter int unsigned MAX_TICKS  = tick_pkg::MAX_TICKS,
  parameter int unsigned DEB_CYCLES = CLK_F / 100
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        btn,
  input  logic [tick_pkg::TICK_W-1:0] target,
  input  logic [tick_pkg::TICK_W-1:0] gen_ticks,
  output logic                        gen_start,
  output logic [tick_pkg::TICK_W-1:0] res_ticks,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic                        busy,
  output logic                        overflow
);

  import tick_pkg::*;

  localparam logic [TICK_W-1:0] MAX_T = TICK_W'(MAX_TICKS);

  logic              btn_clean;
  logic              btn_prev_q;
  logic              btn_rise;
  logic              btn_fall;

  state_t            state_q;
  state_t            state_d;
  logic [TICK_W-1:0] tgt_q;
  logic [TICK_W-1:0] tgt_d;
  logic              gen_start_q;
  logic              gen_start_d;
  logic [TICK_W-1:0] res_ticks_q;
  logic [TICK_W-1:0] res_ticks_d;
  logic              res_valid_q;
  logic              res_valid_d;
  logic              overflow_q;
  logic              overflow_d;

  logic              end_tgt;
  logic              end_sat;
  logic              end_rel;

  btn_debouncer #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_btn_debouncer (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_i       (btn),
    .btn_clean_o (btn_clean)
  );

  assign btn_rise = btn_clean & ~btn_prev_q;
  assign btn_fall = ~btn_clean & btn_prev_q;

  // Ending conditions; the target test wins over saturation, which wins over release.
  // A target above MAX_TICKS is never reached, so saturation ends that session.
  assign end_tgt = (tgt_q != '0) && (gen_ticks >= tgt_q);
  assign end_sat = (gen_ticks == MAX_T);
  assign end_rel = btn_fall;

  // Session FSM next-state and output-register logic
  always_comb begin
    state_d     = state_q;
    tgt_d       = tgt_q;
    gen_start_d = gen_start_q;
    res_ticks_d = res_ticks_q;
    res_valid_d = res_valid_q;
    overflow_d  = overflow_q;
    case (state_q)
      ST_IDLE: begin
        if (btn_rise) begin
          tgt_d       = target;
          gen_start_d = 1'b1;
          state_d     = ST_RUN;
        end
      end
      ST_RUN: begin
        if (end_tgt || end_sat || end_rel) begin
          res_ticks_d = clamp_ticks(gen_ticks, tgt_q);
          overflow_d  = !end_tgt && end_sat;
          gen_start_d = 1'b0;
          state_d     = ST_STOP;
        end
      end
      ST_STOP: begin
        res_valid_d = 1'b1;
        state_d     = ST_REPORT;
      end
      ST_REPORT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        gen_start_d = 1'b0;
        res_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // State registers; reset discards any session in progress
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      tgt_q       <= '0;
      gen_start_q <= 1'b0;
      res_ticks_q <= '0;
      res_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      btn_prev_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      tgt_q       <= tgt_d;
      gen_start_q <= gen_start_d;
      res_ticks_q <= res_ticks_d;
      res_valid_q <= res_valid_d;
      overflow_q  <= overflow_d;
      btn_prev_q  <= btn_clean;
    end
  end

  assign gen_start = gen_start_q;
  assign res_ticks = res_ticks_q;
  assign res_valid = res_valid_q;
  assign overflow  = overflow_q;
  assign busy      = (state_q != ST_IDLE);

endmodule
